// File: rtl/multicycle_control.sv
// Multicycle RV32/RV64 integer control unit: owns PC, old PC and the instruction register.
// Optional JAL support is built when MULTICYCLE_JAL_EN is defined; otherwise jal traps.
module multicycle_control #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req,
   input  logic            mem_ready,
   output logic            mem_we,
   output logic            addr_sel,
   input  logic [31:0]     mem_rdata,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] old_pc,
   output logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [1:0]      alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic            reg_write,
   output logic            mem2reg,
   output logic [3:0]      state,
   output logic            illegal
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_JAL     = 4'd9,
      S_TRAP    = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] old_pc_q, old_pc_d;
   logic [31:0]     ir_q, ir_d;
   logic            illegal_q, illegal_d;
   logic            mem_req_s;
   logic            unused_s;

   // The ALU result is routed to memory by the datapath; control never inspects it.
   assign unused_s = ^alu_result;

   // State and architectural register update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         old_pc_q  <= RESET_PC;
         ir_q      <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         old_pc_q  <= old_pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and PC/IR sequencing
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      old_pc_d  = old_pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d     = mem_rdata;
               old_pc_d = pc_q;
               pc_d     = pc_q + XLEN'(4);
               state_d  = S_DECODE;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_DECODE: begin
            case (ir_q[6:0])
               OP_LOAD, OP_STORE: state_d = S_MEMADDR;
               OP_REG, OP_IMM:    state_d = S_EXEC;
               OP_BR:             state_d = S_BRANCH;
`ifdef MULTICYCLE_JAL_EN
               OP_JAL:            state_d = S_JAL;
`endif
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            if (ir_q[6:0] == OP_STORE) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMRD: begin
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: begin
            if (alu_zero) begin
               pc_d = target;
            end else begin
               pc_d = pc_q;
            end
            state_d = S_FETCH;
         end
`ifdef MULTICYCLE_JAL_EN
         S_JAL: begin
            pc_d    = target;
            state_d = S_FETCH;
         end
`endif
         S_TRAP: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
         end
         default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
         end
      endcase
   end

   // Moore control decode
   always_comb begin
      mem_req_s = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      alu_op    = 2'b00;
      reg_write = 1'b0;
      mem2reg   = 1'b0;
      case (state_q)
         S_FETCH:   mem_req_s = 1'b1;
         S_MEMADDR: alu_src_b = 2'd1;
         S_MEMRD: begin
            mem_req_s = 1'b1;
            addr_sel  = 1'b1;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            mem2reg   = 1'b1;
         end
         S_MEMWR: begin
            mem_req_s = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = 1'b1;
         end
         S_EXEC: begin
            alu_op    = 2'b10;
            alu_src_b = (ir_q[6:0] == OP_REG) ? 2'd0 : 2'd1;
         end
         S_ALUWB:   reg_write = 1'b1;
         S_BRANCH:  alu_op = 2'b01;
`ifdef MULTICYCLE_JAL_EN
         S_JAL: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            reg_write = 1'b1;
         end
`endif
         default: begin
            mem_req_s = 1'b0;
         end
      endcase
   end

   // No request may escape while reset is held, even though state already reads FETCH.
   assign mem_req = mem_req_s & reset;
   assign pc      = pc_q;
   assign old_pc  = old_pc_q;
   assign instr   = ir_q;
   assign opcode  = ir_q[6:0];
   assign funct3  = ir_q[14:12];
   assign funct7  = ir_q[31:25];
   assign state   = state_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (32-bit and 64-bit instances).
// Exercises the JAL path when MULTICYCLE_JAL_EN is defined, the trap path otherwise.
module tb_multicycle_control;

   logic        clk;
   logic        reset;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [31:0] target;
   logic        mem_req, mem_we, addr_sel, reg_write, mem2reg, illegal;
   logic [31:0] pc, old_pc, instr;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [1:0]  alu_src_a, alu_src_b, alu_op;
   logic [3:0]  state;

   logic        reset64, ready64;
   logic [31:0] rdata64;
   logic [63:0] alu_result64, target64, pc64, old_pc64;
   logic        mem_req64, mem_we64, addr_sel64, reg_write64, mem2reg64, illegal64;
   logic [31:0] instr64;
   logic [6:0]  opcode64, funct7_64;
   logic [2:0]  funct3_64;
   logic [1:0]  src_a64, src_b64, alu_op64;
   logic [3:0]  state64;

   int checks = 0;
   int errors = 0;

   multicycle_control #(.XLEN(32), .RESET_PC(32'd0)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we),
      .addr_sel(addr_sel), .mem_rdata(mem_rdata), .alu_result(alu_result), .alu_zero(alu_zero),
      .target(target), .pc(pc), .old_pc(old_pc), .instr(instr), .opcode(opcode),
      .funct3(funct3), .funct7(funct7), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .mem2reg(mem2reg), .state(state), .illegal(illegal)
   );

   multicycle_control #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut64 (
      .clk(clk), .reset(reset64), .mem_req(mem_req64), .mem_ready(ready64), .mem_we(mem_we64),
      .addr_sel(addr_sel64), .mem_rdata(rdata64), .alu_result(alu_result64), .alu_zero(1'b0),
      .target(target64), .pc(pc64), .old_pc(old_pc64), .instr(instr64), .opcode(opcode64),
      .funct3(funct3_64), .funct7(funct7_64), .alu_src_a(src_a64), .alu_src_b(src_b64),
      .alu_op(alu_op64), .reg_write(reg_write64), .mem2reg(mem2reg64), .state(state64),
      .illegal(illegal64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state); end
      checks++; if (pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h exp 0", pc); end
      checks++; if (old_pc !== 32'd0) begin errors++; $display("FAIL rst_old_pc: got %h exp 0", old_pc); end
      checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rst_ir: got %h exp 0", instr); end
      checks++; if ({mem_req, mem_we, addr_sel, reg_write, mem2reg, illegal} !== 6'd0) begin
         errors++; $display("FAIL rst_ctrl: got %b exp 000000", {mem_req, mem_we, addr_sel, reg_write, mem2reg, illegal}); end
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
      #1;
      checks++; if (mem_req !== 1'b1 || addr_sel !== 1'b0) begin
         errors++; $display("FAIL fetch_req: got req=%b sel=%b exp 1/0", mem_req, addr_sel); end
   endtask

   task automatic test_addi();
      int wr_cnt;
      wr_cnt = 0;
      tick(); wr_cnt += int'(reg_write);
      checks++; if (state !== 4'd1 || pc !== 32'd4 || old_pc !== 32'd0) begin
         errors++; $display("FAIL addi_decode: got st=%0d pc=%h old=%h exp 1/4/0", state, pc, old_pc); end
      checks++; if (instr !== 32'h0050_0093 || opcode !== 7'h13) begin
         errors++; $display("FAIL addi_ir: got %h op=%h exp 00500093/13", instr, opcode); end
      tick(); wr_cnt += int'(reg_write);
      checks++; if (state !== 4'd6 || alu_op !== 2'b10 || alu_src_b !== 2'd1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL addi_exec: got st=%0d op=%b b=%0d req=%b exp 6/10/1/0", state, alu_op, alu_src_b, mem_req); end
      tick(); wr_cnt += int'(reg_write);
      checks++; if (state !== 4'd7 || reg_write !== 1'b1 || mem2reg !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL addi_wb: got st=%0d wr=%b m2r=%b req=%b exp 7/1/0/0", state, reg_write, mem2reg, mem_req); end
      tick(); wr_cnt += int'(reg_write);
      checks++; if (state !== 4'd0 || mem_req !== 1'b1 || pc !== 32'd4) begin
         errors++; $display("FAIL addi_refetch: got st=%0d req=%b pc=%h exp 0/1/4", state, mem_req, pc); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL addi_wr_once: got %0d exp 1", wr_cnt); end
   endtask

   task automatic test_load_wait();
      mem_rdata = 32'h0000_A103;
      tick(); mem_ready = 1'b0;
      checks++; if (state !== 4'd1 || funct3 !== 3'b010) begin
         errors++; $display("FAIL ld_decode: got st=%0d f3=%b exp 1/010", state, funct3); end
      tick();
      checks++; if (state !== 4'd2 || alu_src_a !== 2'd0 || alu_src_b !== 2'd1 || alu_op !== 2'b00) begin
         errors++; $display("FAIL ld_memaddr: got st=%0d a=%0d b=%0d op=%b exp 2/0/1/00", state, alu_src_a, alu_src_b, alu_op); end
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if (state !== 4'd3 || mem_req !== 1'b1 || addr_sel !== 1'b1 || mem_we !== 1'b0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL ld_memrd_%0d: got st=%0d req=%b sel=%b we=%b wr=%b exp 3/1/1/0/0", i, state, mem_req, addr_sel, mem_we, reg_write); end
         if (i == 3) mem_ready = 1'b1;
         tick();
      end
      checks++; if (state !== 4'd4 || reg_write !== 1'b1 || mem2reg !== 1'b1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL ld_memwb: got st=%0d wr=%b m2r=%b req=%b exp 4/1/1/0", state, reg_write, mem2reg, mem_req); end
      tick();
      checks++; if (state !== 4'd0 || pc !== 32'd8) begin
         errors++; $display("FAIL ld_done: got st=%0d pc=%h exp 0/8", state, pc); end
   endtask

   task automatic test_branch();
      mem_rdata = 32'h0000_0063; alu_zero = 1'b1; target = 32'h40;
      tick();
      checks++; if (old_pc !== 32'd8 || pc !== 32'hC) begin
         errors++; $display("FAIL br_decode: got old=%h pc=%h exp 8/c", old_pc, pc); end
      tick();
      checks++; if (state !== 4'd8 || alu_op !== 2'b01 || alu_src_a !== 2'd0 || alu_src_b !== 2'd0) begin
         errors++; $display("FAIL br_state: got st=%0d op=%b a=%0d b=%0d exp 8/01/0/0", state, alu_op, alu_src_a, alu_src_b); end
      tick();
      checks++; if (state !== 4'd0 || pc !== 32'h40) begin
         errors++; $display("FAIL br_taken: got st=%0d pc=%h exp 0/40", state, pc); end
      target = 32'h8;
      tick(); tick(); tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_back: got pc=%h exp 8", pc); end
      alu_zero = 1'b0; target = 32'h40;
      tick(); tick(); tick();
      checks++; if (state !== 4'd0 || pc !== 32'hC) begin
         errors++; $display("FAIL br_not_taken: got st=%0d pc=%h exp 0/c", state, pc); end
   endtask

   task automatic test_store();
      mem_rdata = 32'h0020_2023;
      tick(); tick(); tick();
      checks++; if (state !== 4'd5 || mem_req !== 1'b1 || mem_we !== 1'b1 || addr_sel !== 1'b1 || reg_write !== 1'b0) begin
         errors++; $display("FAIL st_memwr: got st=%0d req=%b we=%b sel=%b wr=%b exp 5/1/1/1/0", state, mem_req, mem_we, addr_sel, reg_write); end
      tick();
      checks++; if (state !== 4'd0 || pc !== 32'h10 || mem_we !== 1'b0) begin
         errors++; $display("FAIL st_done: got st=%0d pc=%h we=%b exp 0/10/0", state, pc, mem_we); end
   endtask

   task automatic test_reset_abandon();
      mem_ready = 1'b0;
      tick();
      checks++; if (state !== 4'd0 || pc !== 32'h10 || mem_req !== 1'b1) begin
         errors++; $display("FAIL stall_fetch: got st=%0d pc=%h req=%b exp 0/10/1", state, pc, mem_req); end
      reset = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || pc !== 32'd0 || state !== 4'd0) begin
         errors++; $display("FAIL abandon: got req=%b pc=%h st=%0d exp 0/0/0", mem_req, pc, state); end
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b1 || addr_sel !== 1'b0 || pc !== 32'd0) begin
         errors++; $display("FAIL refetch_rst: got req=%b sel=%b pc=%h exp 1/0/0", mem_req, addr_sel, pc); end
   endtask

   task automatic test_trap();
      mem_rdata = 32'hFFFF_FFFF;
      tick(); tick();
      checks++; if (state !== 4'd10 || illegal !== 1'b1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL trap_enter: got st=%0d ill=%b req=%b exp 10/1/0", state, illegal, mem_req); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_req !== 1'b0 || reg_write !== 1'b0 || pc !== 32'd4 || instr !== 32'hFFFF_FFFF || illegal !== 1'b1) begin
            errors++; $display("FAIL trap_hold_%0d: got req=%b wr=%b pc=%h ir=%h ill=%b", i, mem_req, reg_write, pc, instr, illegal); end
      end
      reset = 1'b0;
      #1;
      checks++; if (illegal !== 1'b0 || pc !== 32'd0 || state !== 4'd0) begin
         errors++; $display("FAIL trap_reset: got ill=%b pc=%h st=%0d exp 0/0/0", illegal, pc, state); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_jal();
      mem_rdata = 32'h0080_00EF; target = 32'h20; mem_ready = 1'b1;
      tick(); tick();
`ifdef MULTICYCLE_JAL_EN
      checks++; if (state !== 4'd9 || reg_write !== 1'b1 || alu_src_b !== 2'd2 || alu_src_a !== 2'd1 || mem_req !== 1'b0) begin
         errors++; $display("FAIL jal_state: got st=%0d wr=%b b=%0d a=%0d req=%b exp 9/1/2/1/0", state, reg_write, alu_src_b, alu_src_a, mem_req); end
      tick();
      checks++; if (state !== 4'd0 || pc !== 32'h20) begin
         errors++; $display("FAIL jal_target: got st=%0d pc=%h exp 0/20", state, pc); end
`else
      checks++; if (state !== 4'd10 || illegal !== 1'b1 || reg_write !== 1'b0) begin
         errors++; $display("FAIL jal_trap: got st=%0d ill=%b wr=%b exp 10/1/0", state, illegal, reg_write); end
`endif
   endtask

   task automatic test_xlen64_wrap();
      checks++; if (pc64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         errors++; $display("FAIL x64_rst_pc: got %h exp fffffffffffffffc", pc64); end
      @(negedge clk);
      reset64 = 1'b1; ready64 = 1'b1; rdata64 = 32'h0050_0093;
      tick();
      checks++; if (pc64 !== 64'd0 || old_pc64 !== 64'hFFFF_FFFF_FFFF_FFFC || state64 !== 4'd1) begin
         errors++; $display("FAIL x64_wrap: got pc=%h old=%h st=%0d exp 0/fffffffffffffffc/1", pc64, old_pc64, state64); end
   endtask

   initial begin
      reset = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0; alu_result = 32'd0;
      alu_zero = 1'b0; target = 32'd0;
      reset64 = 1'b0; ready64 = 1'b0; rdata64 = 32'd0; alu_result64 = 64'd0; target64 = 64'd0;
      test_reset();
      test_addi();
      test_load_wait();
      test_branch();
      test_store();
      test_reset_abandon();
      test_trap();
      test_jal();
      test_xlen64_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
